// File: rtl/prbs_pkg.sv
// Shared LFSR helpers for the event generator bank: tap table, seed
// derivation and one-step advance.
package prbs_pkg;

  localparam logic [63:0] SEED_HASH = 64'h9E37_79B9_7F4A_7C15;

  function automatic logic [63:0] width_mask(input int width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  // Tap n maps to bit n-1 of the mask.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      16:      return 64'h0000_0000_0000_D008;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0;
    endcase
  endfunction

  // All-ones is the XNOR lock-up state, so it is never handed out as a seed.
  function automatic logic [63:0] seed_for(input logic [63:0] base, input int k,
                                           input int width);
    logic [63:0] h;
    h = (base ^ (64'(k) * SEED_HASH)) & width_mask(width);
    if (h == width_mask(width)) h[0] = 1'b0;
    return h;
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] mask,
                                            input int width);
    logic fb;
    fb = ~^(state & mask);
    return ((state << 1) | {63'd0, fb}) & width_mask(width);
  endfunction

endpackage

// File: rtl/prbs_lane.sv
// One channel: XNOR LFSR, programmable threshold/mode, comparator and
// registered event bit.
module prbs_lane
  import prbs_pkg::*;
#(
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] SEED      = 1,
  parameter logic [LFSR_W-1:0] THR_INIT  = 2,
  parameter bit                MODE_INIT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_reseed,
  input  logic              i_we,
  input  logic [LFSR_W-1:0] i_thr,
  input  logic              i_mode,
  output logic              o_event
);

  localparam logic [63:0] TAPS = lfsr_taps(LFSR_W);

  logic [LFSR_W-1:0] r_state, r_thr;
  logic              r_mode, r_event;
  logic [LFSR_W-1:0] w_next;
  logic              w_hit;

  assign w_next  = LFSR_W'(lfsr_next(64'(r_state), TAPS, LFSR_W));
  assign w_hit   = r_mode ? (r_state < r_thr) : (r_state >= r_thr);
  assign o_event = r_event;

  // Compare sees the pre-advance state and pre-write threshold of this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEED;
      r_thr   <= THR_INIT;
      r_mode  <= MODE_INIT;
      r_event <= 1'b0;
    end else begin
      if (i_reseed)  r_state <= SEED;
      else if (i_en) r_state <= w_next;
      if (i_en) r_event <= w_hit;
      if (i_we) begin
        r_thr  <= i_thr;
        r_mode <= i_mode;
      end
    end
  end

endmodule

// File: rtl/prbs_bank.sv
// Multi-channel Bernoulli event generator with per-channel saturating
// event counters and a registered counter read port.
module prbs_bank
  import prbs_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          LFSR_W    = 32,
  parameter logic [63:0] SEED_BASE = 64'd1,
  parameter logic [63:0] THR_INIT  = 64'd2,
  parameter bit          MODE_INIT = 1'b0,
  parameter int          CNT_W     = 32,
  localparam int         AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              reseed,
  input  logic              thr_we,
  input  logic [AW-1:0]     thr_addr,
  input  logic [LFSR_W-1:0] thr_data,
  input  logic              mode_data,
  input  logic              cnt_clr,
  input  logic [AW-1:0]     rd_addr,
  output logic [NUM_CH-1:0] event_out,
  output logic              event_valid,
  output logic [CNT_W-1:0]  rd_data
);

  if (!(LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32 || LFSR_W == 64)) begin : g_bad_w
    $error("prbs_bank: LFSR_W must be 16, 24, 32 or 64");
  end
  if (NUM_CH < 1 || NUM_CH > 64) begin : g_bad_ch
    $error("prbs_bank: NUM_CH must be 1..64");
  end

  logic                         r_valid;
  logic [CNT_W-1:0]             r_rd;
  logic [NUM_CH-1:0]            w_ev;
  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic             w_we;
    logic [CNT_W-1:0] r_cnt;

    // Out-of-range addresses simply match no lane.
    assign w_we = thr_we && (int'(thr_addr) == k);

    prbs_lane #(
      .LFSR_W    (LFSR_W),
      .SEED      (LFSR_W'(seed_for(SEED_BASE, k, LFSR_W))),
      .THR_INIT  (THR_INIT[LFSR_W-1:0]),
      .MODE_INIT (MODE_INIT)
    ) u_lane (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_en     (en),
      .i_reseed (reseed),
      .i_we     (w_we),
      .i_thr    (thr_data),
      .i_mode   (mode_data),
      .o_event  (w_ev[k])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        r_cnt <= '0;
      else if (cnt_clr)                               r_cnt <= '0;
      else if (r_valid && w_ev[k] && (r_cnt != '1))   r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_cnt[k] = r_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_valid <= en;
      r_rd    <= (int'(rd_addr) < NUM_CH) ? w_cnt[rd_addr] : '0;
    end
  end

  assign event_out   = w_ev;
  assign event_valid = r_valid;
  assign rd_data     = r_rd;

endmodule

// File: tb/tb_prbs_bank.sv
// Directed bench for prbs_bank: three instances (32-bit/4ch, 16-bit/3ch,
// 32-bit/4-bit counters) driven from one shared stimulus sequence.
module tb_prbs_bank;

  logic        clk = 1'b0;
  logic        rst, en, reseed, thr_we, mode_data, cnt_clr;
  logic [1:0]  thr_addr, rd_addr;
  logic [31:0] thr_data;

  logic [3:0]  ev32, ev4;
  logic [2:0]  ev16;
  logic        vld32, vld16, vld4;
  logic [31:0] rd32, rd16;
  logic [3:0]  rd4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs_bank dut (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .thr_we(thr_we),
    .thr_addr(thr_addr), .thr_data(thr_data), .mode_data(mode_data),
    .cnt_clr(cnt_clr), .rd_addr(rd_addr),
    .event_out(ev32), .event_valid(vld32), .rd_data(rd32));

  prbs_bank #(.NUM_CH(3), .LFSR_W(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .thr_we(thr_we),
    .thr_addr(thr_addr), .thr_data(thr_data[15:0]), .mode_data(mode_data),
    .cnt_clr(cnt_clr), .rd_addr(rd_addr),
    .event_out(ev16), .event_valid(vld16), .rd_data(rd16));

  prbs_bank #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .thr_we(thr_we),
    .thr_addr(thr_addr), .thr_data(thr_data), .mode_data(mode_data),
    .cnt_clr(cnt_clr), .rd_addr(rd_addr),
    .event_out(ev4), .event_valid(vld4), .rd_data(rd4));

  logic [31:0] st32 [4];
  logic [15:0] st16 [3];
  logic [15:0] thr16 [3];
  logic        mode16 [3];

  for (genvar g = 0; g < 4; g++) begin : g_tap32
    assign st32[g] = dut.g_lane[g].u_lane.r_state;
  end
  for (genvar g = 0; g < 3; g++) begin : g_tap16
    assign st16[g]   = dut16.g_lane[g].u_lane.r_state;
    assign thr16[g]  = dut16.g_lane[g].u_lane.r_thr;
    assign mode16[g] = dut16.g_lane[g].u_lane.r_mode;
  end

  // Hand-derived seeds: base 1 xor k*0x...7F4A7C15, truncated.
  logic [31:0] seed32 [4] = '{32'h0000_0001, 32'h7F4A_7C14, 32'hFE94_F82B, 32'h7DDF_743E};
  logic [15:0] seed16 [3] = '{16'h0001, 16'h7C14, 16'hF82B};
  logic [31:0] hand0  [3] = '{32'd2, 32'd4, 32'd9};

  logic [31:0] m32 [4];
  logic [15:0] m16 [3];
  logic [3:0]  e32;
  logic [2:0]  e16;
  logic [6:0]  gold [64];
  logic [6:0]  cap1 [64];

  function automatic logic [31:0] nxt32(input logic [31:0] s);
    return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
  endfunction

  function automatic logic [15:0] nxt16(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic m);
    thr_we = 1'b1; thr_addr = a; thr_data = d; mode_data = m;
    step();
    thr_we = 1'b0;
  endtask

  task automatic run_counts(input int n);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    en = 1'b1;
    repeat (n) step();
    en = 1'b0;
    rd_addr = 2'd0; step(); step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; reseed = 1'b0; thr_we = 1'b0; mode_data = 1'b0;
    cnt_clr = 1'b0; thr_addr = '0; rd_addr = '0; thr_data = '0;
    step(); step();

    // Reset state
    chk("rst ev32", 64'(ev32), 64'd0);
    chk("rst vld32", 64'(vld32), 64'd0);
    chk("rst rd32", 64'(rd32), 64'd0);
    chk("rst st32[0]", 64'(st32[0]), 64'd1);
    chk("rst st32[1]", 64'(st32[1]), 64'h7F4A_7C14);
    chk("rst st16[1]", 64'(st16[1]), 64'h7C14);

    // Golden sequence, threshold 2 / mode 0 everywhere
    for (int k = 0; k < 4; k++) m32[k] = seed32[k];
    for (int k = 0; k < 3; k++) m16[k] = seed16[k];
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) e32[k] = (m32[k] >= 32'd2);
      for (int k = 0; k < 3; k++) e16[k] = (m16[k] >= 16'd2);
      step();
      for (int k = 0; k < 4; k++) begin
        m32[k] = nxt32(m32[k]);
        chk($sformatf("gold st32[%0d] cyc %0d", k, i), 64'(st32[k]), 64'(m32[k]));
      end
      for (int k = 0; k < 3; k++) begin
        m16[k] = nxt16(m16[k]);
        chk($sformatf("gold st16[%0d] cyc %0d", k, i), 64'(st16[k]), 64'(m16[k]));
      end
      chk($sformatf("gold ev32 cyc %0d", i), 64'(ev32), 64'(e32));
      chk($sformatf("gold ev16 cyc %0d", i), 64'(ev16), 64'(e16));
      if (i < 3) chk($sformatf("hand st32[0] cyc %0d", i), 64'(st32[0]), 64'(hand0[i]));
      if (i < 64) gold[i] = {ev16, ev32};
    end
    chk("gold vld32", 64'(vld32), 64'd1);

    // Extremes, mode 0
    en = 1'b0; step();
    wr(2'd0, 32'h0, 1'b0);
    wr(2'd1, 32'hFFFF_FFFF, 1'b0);
    run_counts(500);
    chk("ext m0 cnt0 w32", 64'(rd32), 64'd500);
    chk("ext m0 cnt0 w16", 64'(rd16), 64'd500);
    chk("ext m0 cnt0 c4", 64'(rd4), 64'd15);
    rd_addr = 2'd1; step();
    chk("ext m0 cnt1 w32", 64'(rd32), 64'd0);
    chk("ext m0 cnt1 w16", 64'(rd16), 64'd0);

    // Extremes, mode 1: counts swap
    wr(2'd0, 32'h0, 1'b1);
    wr(2'd1, 32'hFFFF_FFFF, 1'b1);
    run_counts(500);
    chk("ext m1 cnt0 w32", 64'(rd32), 64'd0);
    rd_addr = 2'd1; step();
    chk("ext m1 cnt1 w32", 64'(rd32), 64'd500);
    chk("ext m1 cnt1 w16", 64'(rd16), 64'd500);

    // Saturation and clear priority
    wr(2'd0, 32'h0, 1'b0);
    run_counts(20);
    chk("sat c4", 64'(rd4), 64'd15);
    chk("sat w32", 64'(rd32), 64'd20);
    en = 1'b1; step();
    en = 1'b0; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0; step();
    chk("clr prio c4", 64'(rd4), 64'd0);
    chk("clr prio w32", 64'(rd32), 64'd0);

    // Reseed repeatability
    wr(2'd0, 32'h8000_0000, 1'b0);
    wr(2'd1, 32'h8000_0000, 1'b0);
    reseed = 1'b1; step(); reseed = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("reseed st32[%0d]", k), 64'(st32[k]), 64'(seed32[k]));
    en = 1'b1;
    for (int i = 0; i < 64; i++) begin step(); cap1[i] = {ev16, ev32}; end
    en = 1'b0; reseed = 1'b1; step(); reseed = 1'b0; en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      chk($sformatf("reseed rep cyc %0d", i), 64'({ev16, ev32}), 64'(cap1[i]));
    end

    // Asynchronous reset mid-run, compared with the power-up run
    repeat (5) step();
    #3 rst = 1'b1;
    #1;
    chk("async rst ev32", 64'(ev32), 64'd0);
    chk("async rst vld32", 64'(vld32), 64'd0);
    chk("async rst st32[0]", 64'(st32[0]), 64'd1);
    chk("async rst thr16[0]", 64'(thr16[0]), 64'd2);
    step(); rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      chk($sformatf("rst rep cyc %0d", i), 64'({ev16, ev32}), 64'(gold[i]));
    end

    // Write collision on ch2: old threshold this edge, new one next edge
    en = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    wr(2'd2, 32'hFFFF_FFFF, 1'b0);
    chk("coll old ev32[2]", 64'(ev32[2]), 64'd1);
    chk("coll old ev16[2]", 64'(ev16[2]), 64'd1);
    step();
    chk("coll new ev32[2]", 64'(ev32[2]), 64'd0);
    chk("coll new ev16[2]", 64'(ev16[2]), 64'd0);

    // Out-of-range write on the 3-channel instance changes nothing
    en = 1'b0;
    wr(2'd3, 32'h0, 1'b1);
    chk("oob thr16[0]", 64'(thr16[0]), 64'd2);
    chk("oob thr16[1]", 64'(thr16[1]), 64'd2);
    chk("oob thr16[2]", 64'(thr16[2]), 64'hFFFF);
    chk("oob mode16", 64'({mode16[2], mode16[1], mode16[0]}), 64'd0);
    en = 1'b1; repeat (4) step(); en = 1'b0;
    rd_addr = 2'd0; step(); step();
    chk("oob rd16 ch0 nonzero", 64'(rd16 != 0), 64'd1);
    rd_addr = 2'd3; step();
    chk("oob rd16 addr3", 64'(rd16), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
